// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix_mac_engine datapath and control.
// Holds the FSM state encoding, the run-time dimension type and the
// saturating narrow helper used when MATRIX_MAC_SATURATE_EN is defined.

package matrix_pkg;

   // Largest supported run-time dimension and the width needed to hold it.
   localparam int MM_MAX_DIM = 64;
   localparam int MM_DIM_W   = $clog2(MM_MAX_DIM + 1);

   typedef logic [MM_DIM_W-1:0] dim_t;

   // Control states for one Z = X*Y run.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      FIN   = 3'd4
   } mm_state_t;

   // Clamp a signed value into the two's complement range of 'width' bits.
   // The result is still 64 bits wide; callers keep the low 'width' bits.
   function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] value,
                                                      input int unsigned width);
      logic signed [63:0] max_val;
      logic signed [63:0] min_val;
      max_val = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_val = -(64'sd1 <<< (width - 1));
      if (value > max_val) begin
         return max_val;
      end
      if (value < min_val) begin
         return min_val;
      end
      return value;
   endfunction

endpackage

// File: rtl/mac_unit.sv
// Multiply-accumulate slice for matrix_mac_engine.
// Delays the issue strobe by the RAM read latency so products are accumulated
// exactly when the operand data arrives, then scales and narrows the sum.
// Optional feature macro: MATRIX_MAC_SATURATE_EN (clamp instead of wrap).

module mac_unit
   import matrix_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int ACC_WIDTH   = 40,
   parameter int FRAC_BITS   = 8,
   parameter int RAM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  issue_valid,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] x_data,
   input  logic [DATA_WIDTH-1:0] y_data,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int PROD_W = 2 * DATA_WIDTH;

   logic [RAM_LATENCY-1:0]       valid_pipe;
   logic signed [PROD_W-1:0]     product;
   logic signed [ACC_WIDTH-1:0]  product_ext;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic signed [ACC_WIDTH-1:0]  shifted;

   // Shift the issue strobe along so it lines up with the returning RAM data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_pipe <= '0;
      end else begin
         valid_pipe[0] <= issue_valid;
         for (int s = 1; s < RAM_LATENCY; s++) begin
            valid_pipe[s] <= valid_pipe[s-1];
         end
      end
   end

   // Full-precision signed product of the two operands.
   always_comb begin
      product = $signed(x_data) * $signed(y_data);
   end

   assign product_ext = {{(ACC_WIDTH - PROD_W){product[PROD_W-1]}}, product};

   // Accumulate valid products; a clear always wins so each element starts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (valid_pipe[RAM_LATENCY-1]) begin
         acc <= acc + product_ext;
      end
   end

   assign shifted = acc >>> FRAC_BITS;

`ifdef MATRIX_MAC_SATURATE_EN
   logic signed [63:0] wide;
   logic signed [63:0] clamped;
   logic               unused_clamp_bits;

   assign wide              = {{(64 - ACC_WIDTH){shifted[ACC_WIDTH-1]}}, shifted};
   assign clamped           = sat_narrow(wide, DATA_WIDTH);
   assign result            = clamped[DATA_WIDTH-1:0];
   assign unused_clamp_bits = ^clamped[63:DATA_WIDTH];
`else
   logic unused_shift_bits;

   assign result            = shifted[DATA_WIDTH-1:0];
   assign unused_shift_bits = ^shifted[ACC_WIDTH-1:DATA_WIDTH];
`endif

endmodule

// File: rtl/matrix_mac_engine.sv
// Signed fixed-point matrix multiplier Z = X*Y over external synchronous RAMs.
// One MAC per cycle; M, N, K and the base addresses are latched at start.
// Addresses come from running offsets so no address multipliers are needed.
// Optional feature macro: MATRIX_MAC_SATURATE_EN (handled inside mac_unit).

module matrix_mac_engine
   import matrix_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int ACC_WIDTH   = 40,
   parameter int FRAC_BITS   = 8,
   parameter int ADDR_WIDTH  = 16,
   parameter int MAX_DIM     = 64,
   parameter int RAM_LATENCY = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [$clog2(MAX_DIM+1)-1:0]  cfg_rows,
   input  logic [$clog2(MAX_DIM+1)-1:0]  cfg_cols,
   input  logic [$clog2(MAX_DIM+1)-1:0]  cfg_inner,
   input  logic [ADDR_WIDTH-1:0]         x_base,
   input  logic [ADDR_WIDTH-1:0]         y_base,
   input  logic [ADDR_WIDTH-1:0]         z_base,
   output logic [ADDR_WIDTH-1:0]         x_addr,
   output logic [ADDR_WIDTH-1:0]         y_addr,
   input  logic [DATA_WIDTH-1:0]         x_data,
   input  logic [DATA_WIDTH-1:0]         y_data,
   output logic [ADDR_WIDTH-1:0]         z_addr,
   output logic [DATA_WIDTH-1:0]         z_data,
   output logic                          z_wen,
   output logic                          busy,
   output logic                          done
);

   localparam int                DIM_W     = $clog2(MAX_DIM + 1);
   localparam logic [DIM_W-1:0]  MAX_DIM_V = DIM_W'(MAX_DIM);
   localparam logic [DIM_W-1:0]  DIM_ONE   = DIM_W'(1);
   localparam logic [1:0]        DRAIN_END = 2'(RAM_LATENCY - 1);

   mm_state_t state;
   mm_state_t next_state;

   logic [DIM_W-1:0]      m_r;
   logic [DIM_W-1:0]      n_r;
   logic [DIM_W-1:0]      k_r;
   logic [ADDR_WIDTH-1:0] x_base_r;
   logic [ADDR_WIDTH-1:0] y_base_r;
   logic [ADDR_WIDTH-1:0] z_base_r;

   logic [DIM_W-1:0]      i_cnt;
   logic [DIM_W-1:0]      j_cnt;
   logic [DIM_W-1:0]      k_cnt;
   logic [1:0]            drain_cnt;

   logic [ADDR_WIDTH-1:0] x_row_off;
   logic [ADDR_WIDTH-1:0] x_off;
   logic [ADDR_WIDTH-1:0] y_off;
   logic [ADDR_WIDTH-1:0] z_off;

   logic [ADDR_WIDTH-1:0] n_ext;
   logic [ADDR_WIDTH-1:0] k_ext;
   logic [ADDR_WIDTH-1:0] j_ext;

   logic                  cfg_bad;
   logic                  last_k;
   logic                  last_col;
   logic                  last_row;
   logic                  drain_last;

   logic                  issue_valid;
   logic                  acc_clear;
   logic [DATA_WIDTH-1:0] mac_result;

   assign cfg_bad = (cfg_rows == '0) || (cfg_cols == '0) || (cfg_inner == '0) ||
                    (cfg_rows > MAX_DIM_V) || (cfg_cols > MAX_DIM_V) ||
                    (cfg_inner > MAX_DIM_V);

   assign last_k     = (k_cnt == k_r - DIM_ONE);
   assign last_col   = (j_cnt == n_r - DIM_ONE);
   assign last_row   = (i_cnt == m_r - DIM_ONE);
   assign drain_last = (drain_cnt == DRAIN_END);

   assign n_ext = ADDR_WIDTH'(n_r);
   assign k_ext = ADDR_WIDTH'(k_r);
   assign j_ext = ADDR_WIDTH'(j_cnt);

   // State register; reset aborts any run in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and output decode; all outputs are quiet outside their own state.
   always_comb begin
      next_state  = state;
      busy        = 1'b0;
      done        = 1'b0;
      z_wen       = 1'b0;
      x_addr      = '0;
      y_addr      = '0;
      z_addr      = '0;
      z_data      = '0;
      issue_valid = 1'b0;
      acc_clear   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = cfg_bad ? FIN : ISSUE;
            end
         end
         ISSUE: begin
            busy        = 1'b1;
            issue_valid = 1'b1;
            x_addr      = x_base_r + x_off;
            y_addr      = y_base_r + y_off;
            if (last_k) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (drain_last) begin
               next_state = WRITE;
            end
         end
         WRITE: begin
            busy       = 1'b1;
            z_wen      = 1'b1;
            z_addr     = z_base_r + z_off;
            z_data     = mac_result;
            acc_clear  = 1'b1;
            next_state = (last_row && last_col) ? FIN : ISSUE;
         end
         FIN: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Configuration latch plus loop counters and running address offsets.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_r       <= '0;
         n_r       <= '0;
         k_r       <= '0;
         x_base_r  <= '0;
         y_base_r  <= '0;
         z_base_r  <= '0;
         i_cnt     <= '0;
         j_cnt     <= '0;
         k_cnt     <= '0;
         drain_cnt <= '0;
         x_row_off <= '0;
         x_off     <= '0;
         y_off     <= '0;
         z_off     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  m_r       <= cfg_rows;
                  n_r       <= cfg_cols;
                  k_r       <= cfg_inner;
                  x_base_r  <= x_base;
                  y_base_r  <= y_base;
                  z_base_r  <= z_base;
                  i_cnt     <= '0;
                  j_cnt     <= '0;
                  k_cnt     <= '0;
                  drain_cnt <= '0;
                  x_row_off <= '0;
                  x_off     <= '0;
                  y_off     <= '0;
                  z_off     <= '0;
               end
            end
            ISSUE: begin
               k_cnt     <= k_cnt + DIM_ONE;
               x_off     <= x_off + 1'b1;
               y_off     <= y_off + n_ext;
               drain_cnt <= '0;
            end
            DRAIN: begin
               drain_cnt <= drain_cnt + 1'b1;
            end
            WRITE: begin
               k_cnt     <= '0;
               drain_cnt <= '0;
               z_off     <= z_off + 1'b1;
               if (last_col) begin
                  j_cnt     <= '0;
                  i_cnt     <= i_cnt + DIM_ONE;
                  x_row_off <= x_row_off + k_ext;
                  x_off     <= x_row_off + k_ext;
                  y_off     <= '0;
               end else begin
                  j_cnt <= j_cnt + DIM_ONE;
                  x_off <= x_row_off;
                  y_off <= j_ext + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   mac_unit #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH),
      .FRAC_BITS   (FRAC_BITS),
      .RAM_LATENCY (RAM_LATENCY)
   ) u_mac (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_valid (issue_valid),
      .clear       (acc_clear),
      .x_data      (x_data),
      .y_data      (y_data),
      .result      (mac_result)
   );

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Self-checking bench for matrix_mac_engine.
// Four engines share the operand RAM contents: read latency 1, 2 and 3 with no
// fractional bits, plus a latency-1 engine with 8 fractional bits.
// Expected writes come from a plain matrix model and are queued per run.

module tb_matrix_mac_engine;
   import matrix_pkg::*;

   localparam int NUM_DUT = 4;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } wr_t;

   logic        clk;
   logic        rst_n;
   logic [NUM_DUT-1:0] start;
   dim_t        cfg_rows;
   dim_t        cfg_cols;
   dim_t        cfg_inner;
   logic [15:0] x_base;
   logic [15:0] y_base;
   logic [15:0] z_base;

   logic [15:0] x_addr [NUM_DUT];
   logic [15:0] y_addr [NUM_DUT];
   logic [15:0] z_addr [NUM_DUT];
   logic [15:0] z_data [NUM_DUT];
   logic        z_wen  [NUM_DUT];
   logic        busy   [NUM_DUT];
   logic        done   [NUM_DUT];

   logic [15:0] x_mem [0:1023];
   logic [15:0] y_mem [0:1023];

   wr_t exp_q[$];
   int  sel;
   int  wr_count;
   int  checks;
   int  errors;

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   for (genvar g = 0; g < NUM_DUT; g++) begin : g_dut
      localparam int LAT  = (g == 3) ? 1 : g + 1;
      localparam int FRAC = (g == 3) ? 8 : 0;

      logic [15:0] xp [0:2];
      logic [15:0] yp [0:2];

      // Synchronous RAM read model with LAT cycles of latency.
      always @(posedge clk) begin
         xp[0] <= x_mem[x_addr[g][9:0]];
         yp[0] <= y_mem[y_addr[g][9:0]];
         xp[1] <= xp[0];
         yp[1] <= yp[0];
         xp[2] <= xp[1];
         yp[2] <= yp[1];
      end

      matrix_mac_engine #(
         .DATA_WIDTH  (16),
         .ACC_WIDTH   (40),
         .FRAC_BITS   (FRAC),
         .ADDR_WIDTH  (16),
         .MAX_DIM     (64),
         .RAM_LATENCY (LAT)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .start     (start[g]),
         .cfg_rows  (cfg_rows),
         .cfg_cols  (cfg_cols),
         .cfg_inner (cfg_inner),
         .x_base    (x_base),
         .y_base    (y_base),
         .z_base    (z_base),
         .x_addr    (x_addr[g]),
         .y_addr    (y_addr[g]),
         .x_data    (xp[LAT-1]),
         .y_data    (yp[LAT-1]),
         .z_addr    (z_addr[g]),
         .z_data    (z_data[g]),
         .z_wen     (z_wen[g]),
         .busy      (busy[g]),
         .done      (done[g])
      );
   end

   // Single comparison point: counts the check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference element Z[i][j] straight from the matrix definition.
   function automatic logic [15:0] golden(input int i, input int j, input int n,
                                          input int k, input int frac);
      longint acc;
      longint xv;
      longint yv;
      longint scaled;
      acc = 0;
      for (int kk = 0; kk < k; kk++) begin
         xv  = longint'($signed(x_mem[int'(x_base) + i * k + kk]));
         yv  = longint'($signed(y_mem[int'(y_base) + kk * n + j]));
         acc = acc + xv * yv;
      end
      scaled = acc >>> frac;
`ifdef MATRIX_MAC_SATURATE_EN
      if (scaled > 32767) begin
         scaled = 32767;
      end else if (scaled < -32768) begin
         scaled = -32768;
      end
`endif
      return scaled[15:0];
   endfunction

   // Scoreboard: every write of the selected engine must match the queue head.
   always @(negedge clk) begin
      if (rst_n && z_wen[sel]) begin
         wr_t e;
         wr_count++;
         checkOutput("queue_has_entry", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("z_addr", 32'(z_addr[sel]), 32'(e.addr));
            checkOutput("z_data", 32'(z_data[sel]), 32'(e.data));
         end
      end
   end

   // Queue the expected writes, pulse start, and time the run until done.
   task automatic applyStimulus(input int inst, input int m, input int n, input int k,
                                input int poke_cycle);
      int lat;
      int frac;
      int valid_dims;
      int expected_cycles;
      int cycles;
      lat        = (inst == 3) ? 1 : inst + 1;
      frac       = (inst == 3) ? 8 : 0;
      valid_dims = (m > 0 && n > 0 && k > 0 && m <= 64 && n <= 64 && k <= 64) ? 1 : 0;
      expected_cycles = valid_dims ? m * n * (k + lat + 1) + 1 : 1;
      exp_q.delete();
      if (valid_dims != 0) begin
         for (int i = 0; i < m; i++) begin
            for (int j = 0; j < n; j++) begin
               exp_q.push_back({16'(int'(z_base) + i * n + j), golden(i, j, n, k, frac)});
            end
         end
      end
      sel         = inst;
      wr_count    = 0;
      cfg_rows    = dim_t'(m);
      cfg_cols    = dim_t'(n);
      cfg_inner   = dim_t'(k);
      start[inst] = 1'b1;
      cycles      = 0;
      while (cycles < expected_cycles + 50) begin
         @(negedge clk);
         cycles++;
         if (cycles == 1) begin
            start[inst] = 1'b0;
            checkOutput("busy_after_start", 32'(busy[inst]), 32'(valid_dims));
         end
         if (poke_cycle > 1 && cycles == poke_cycle) begin
            start[inst] = 1'b1;
            cfg_rows    = dim_t'(1);
            cfg_cols    = dim_t'(1);
            cfg_inner   = dim_t'(1);
         end
         if (poke_cycle > 1 && cycles == poke_cycle + 1) begin
            start[inst] = 1'b0;
         end
         if (done[inst]) begin
            break;
         end
      end
      start[inst] = 1'b0;
      checkOutput("done_cycle", 32'(cycles), 32'(expected_cycles));
      checkOutput("write_count", 32'(wr_count), 32'(valid_dims ? m * n : 0));
      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
      start[inst] = 1'b1;
      @(negedge clk);
      start[inst] = 1'b0;
      checkOutput("fin_start_ignored", {30'd0, busy[inst], done[inst]}, 32'd0);
      exp_q.delete();
   endtask

   // Loads a 2x2 identity X and Y = [[1,2],[3,4]].
   task automatic loadIdentity();
      x_mem[100] = 16'd1; x_mem[101] = 16'd0; x_mem[102] = 16'd0; x_mem[103] = 16'd1;
      y_mem[300] = 16'd1; y_mem[301] = 16'd2; y_mem[302] = 16'd3; y_mem[303] = 16'd4;
   endtask

   // Directed sequence of runs.
   initial begin
      checks    = 0;
      errors    = 0;
      sel       = 0;
      wr_count  = 0;
      rst_n     = 1'b0;
      start     = '0;
      cfg_rows  = '0;
      cfg_cols  = '0;
      cfg_inner = '0;
      x_base    = 16'd100;
      y_base    = 16'd300;
      z_base    = 16'd600;
      for (int a = 0; a < 1024; a++) begin
         x_mem[a] = '0;
         y_mem[a] = '0;
      end
      repeat (3) @(negedge clk);

      $display("[TB] reset state");
      for (int g = 0; g < NUM_DUT; g++) begin
         checkOutput("rst_busy", 32'(busy[g]), 32'd0);
         checkOutput("rst_done", 32'(done[g]), 32'd0);
         checkOutput("rst_z_wen", 32'(z_wen[g]), 32'd0);
         checkOutput("rst_x_addr", 32'(x_addr[g]), 32'd0);
         checkOutput("rst_z_data", 32'(z_data[g]), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] identity 2x2 at each latency");
      loadIdentity();
      checkOutput("golden_identity_last", 32'(golden(1, 1, 2, 2, 0)), 32'd4);
      applyStimulus(0, 2, 2, 2, 4);
      applyStimulus(1, 2, 2, 2, 0);
      applyStimulus(2, 2, 2, 2, 0);

      $display("[TB] random 3x4 * 4x2 at each latency");
      for (int r = 0; r < 3; r++) begin
         for (int a = 0; a < 12; a++) begin
            x_mem[100 + a] = 16'($urandom);
         end
         for (int a = 0; a < 8; a++) begin
            y_mem[300 + a] = 16'($urandom);
         end
         applyStimulus(r, 3, 2, 4, (r == 1) ? 6 : 0);
      end

      $display("[TB] fractional scaling 1.5 * 2.0");
      x_mem[100] = 16'h0180;
      y_mem[300] = 16'h0200;
      checkOutput("golden_frac", 32'(golden(0, 0, 1, 1, 8)), 32'h0300);
      applyStimulus(3, 1, 1, 1, 0);

      $display("[TB] overflow, K=4 of 0x7FFF");
      for (int a = 0; a < 4; a++) begin
         x_mem[100 + a] = 16'h7FFF;
         y_mem[300 + a] = 16'h7FFF;
      end
`ifdef MATRIX_MAC_SATURATE_EN
      checkOutput("golden_overflow", 32'(golden(0, 0, 1, 4, 0)), 32'h7FFF);
`else
      checkOutput("golden_overflow", 32'(golden(0, 0, 1, 4, 0)), 32'h0004);
`endif
      applyStimulus(0, 1, 1, 4, 0);

      $display("[TB] degenerate configurations");
      applyStimulus(1, 2, 2, 0, 0);
      applyStimulus(2, 65, 1, 1, 0);

      $display("[TB] reset in the middle of a run");
      loadIdentity();
      exp_q.delete();
      sel       = 0;
      cfg_rows  = dim_t'(2);
      cfg_cols  = dim_t'(2);
      cfg_inner = dim_t'(2);
      start[0]  = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      @(negedge clk);
      checkOutput("mid_x_addr_live", 32'(x_addr[0]), 32'd101);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 32'(busy[0]), 32'd0);
      checkOutput("abort_x_addr", 32'(x_addr[0]), 32'd0);
      checkOutput("abort_y_addr", 32'(y_addr[0]), 32'd0);
      checkOutput("abort_z_wen", 32'(z_wen[0]), 32'd0);
      checkOutput("abort_done", 32'(done[0]), 32'd0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("abort_no_write", 32'(z_wen[0]), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(0, 2, 2, 2, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
